inst_queue: RTL

Instruction prefetch queue between the fetch side (PC register plus instruction ROM) and the decode stage. It accepts one fetched pc/instruction pair per cycle into a small FIFO and presents one pair per cycle to ID through registered outputs. It applies the pipeline stall vector on the decode side and discards all in-flight instructions on a branch flush. It raises a stall request toward the controller when it can accept no more fetches.

---
 rtl/inst_queue_if.sv | 31 +++
 rtl/inst_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/inst_queue_if.sv
// Fetch/decode bundle for the instruction prefetch queue.
// The slave modport is the queue itself; the master modport is the surrounding pipeline.
interface inst_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_i;
    logic [DATA_W-1:0] inst_i;
    logic              inst_valid_i;
    logic              flush_i;
    logic [5:0]        stall;
    logic              stallreq_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;
    logic              id_valid_o;

    modport slave (
        input  pc_i, inst_i, inst_valid_i, flush_i, stall,
        output stallreq_o, count_o, overflow_o, id_pc, id_inst, id_valid_o
    );

    modport master (
        output pc_i, inst_i, inst_valid_i, flush_i, stall,
        input  stallreq_o, count_o, overflow_o, id_pc, id_inst, id_valid_o
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction prefetch queue: circular FIFO between fetch and ID with registered ID outputs.
// Optional INST_QUEUE_BYPASS_EN: an empty queue forwards the incoming fetch straight to ID.
module inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              overflow_reg;
    logic [ADDR_W-1:0] id_pc_reg;
    logic [DATA_W-1:0] id_inst_reg;
    logic              id_valid_reg;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic bypass;
    logic drop;

    always_comb begin
        full   = (count_reg == CNT_W'(DEPTH));
        empty  = (count_reg == '0);
        pop    = !bus.stall[1] && !empty && !bus.flush_i;
`ifdef INST_QUEUE_BYPASS_EN
        bypass = bus.inst_valid_i && !bus.stall[1] && empty && !bus.flush_i;
`else
        bypass = 1'b0;
`endif
        // A full queue still accepts a fetch when the head leaves the same cycle.
        push   = bus.inst_valid_i && !bus.flush_i && !bypass && (!full || pop);
        drop   = bus.inst_valid_i && !bus.flush_i && full && !pop;
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    // Storage has no reset so it maps onto RAM; stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_reg]   <= bus.pc_i;
            inst_mem[tail_reg] <= bus.inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            id_pc_reg    <= '0;
            id_inst_reg  <= '0;
            id_valid_reg <= 1'b0;
        end else if (bus.flush_i) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            id_pc_reg    <= '0;
            id_inst_reg  <= '0;
            id_valid_reg <= 1'b0;
        end else begin
            if (pop)
                head_reg <= head_reg + PTR_W'(1);
            if (push)
                tail_reg <= tail_reg + PTR_W'(1);
            if (drop)
                overflow_reg <= 1'b1;
            count_reg <= count_next;

            // ID outputs only move when decode is not stalled.
            if (!bus.stall[1]) begin
                if (pop) begin
                    id_pc_reg    <= pc_mem[head_reg];
                    id_inst_reg  <= inst_mem[head_reg];
                    id_valid_reg <= 1'b1;
                end else if (bypass) begin
                    id_pc_reg    <= bus.pc_i;
                    id_inst_reg  <= bus.inst_i;
                    id_valid_reg <= 1'b1;
                end else begin
                    id_pc_reg    <= '0;
                    id_inst_reg  <= '0;
                    id_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.stallreq_o = full;
    assign bus.count_o    = count_reg;
    assign bus.overflow_o = overflow_reg;
    assign bus.id_pc      = id_pc_reg;
    assign bus.id_inst    = id_inst_reg;
    assign bus.id_valid_o = id_valid_reg;
endmodule
